lane_deskew_ctrl: RTL and testbench
===================================

LANE_DESKEW_CTRL -- requirements
Module: lane_deskew_ctrl

Interface
REQ-001 Parameter LANE_COUNT, default 32, number of physical lanes (1..32).
REQ-002 Parameter DATA_WIDTH, default 8, symbol width per lane.
REQ-003 Parameter MAX_SKEW, default 6, largest tolerated inter-lane skew in RX_CLK cycles.
REQ-004 Parameter DELAY_WIDTH, default 3, delay_select width; shall hold MAX_SKEW.
REQ-005 Parameter SDS_SYMBOL, default 8'hE1, first-symbol pattern marking SDS.
REQ-006 RX_CLK  input  1  receive clock, all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  LTSSM deskew enable; low forces IDLE.
REQ-009 soft_rst  input  1  synchronous clear, same effect as rst.
REQ-010 active_lanes  input  LANE_COUNT  negotiated link-width mask; bit=1 lane participates.
REQ-011 rx_data  input  LANE_COUNT x DATA_WIDTH  skewed per-lane symbols.
REQ-012 block_type  input  LANE_COUNT  1 = ordered-set block on that lane.
REQ-013 delay_select  output  LANE_COUNT x DELAY_WIDTH  per-lane delay-line tap.
REQ-014 valid_data  output  LANE_COUNT  per-lane data-valid qualifier.
REQ-015 deskew_done  output  1  all active lanes aligned.
REQ-016 deskew_error  output  1  skew exceeded MAX_SKEW.
REQ-017 skew_measured  output  DELAY_WIDTH  arrival spread of last successful lock.

Function
REQ-018 FSM states IDLE, SEARCH, ALIGN, LOCKED, ERROR; state register only.
REQ-019 IDLE->SEARCH when en=1 and active_lanes!=0; mask latched on that edge, changes ignored until IDLE re-entered.
REQ-020 SDS hit on lane i: rx_data[i]==SDS_SYMBOL and block_type[i]=1 and latched mask bit i=1.
REQ-021 SEARCH->ALIGN on first cycle with any hit; skew counter cleared to 0 that cycle; SEARCH->LOCKED directly if all active lanes hit same cycle.
REQ-022 In ALIGN, skew counter +1 per cycle; lane seen flag set on first hit; repeat hits on seen lane ignored.
REQ-023 Each seen lane's delay counter +1 per cycle while ALIGN not complete; final delay_select[i] = last-arrival cycle minus lane i arrival cycle.
REQ-024 ALIGN->LOCKED on cycle all active lanes seen, provided skew counter <= MAX_SKEW; skew_measured loaded with counter value.
REQ-025 ALIGN->ERROR when skew counter == MAX_SKEW and not all active lanes seen; delay_select frozen.
REQ-026 LOCKED: deskew_done=1, delay_select held, further SDS ignored; exits only via en=0, soft_rst, rst.
REQ-027 ERROR: deskew_error=1, deskew_done=0; exit to IDLE only on en=0 or soft_rst.
REQ-028 valid_data[i]: 0 for inactive lanes; 0 for seen lanes during ALIGN; 1 otherwise for active lanes; all active lanes 1 in LOCKED.
REQ-029 en=0 in any state: next cycle IDLE, delays 0, flags cleared, skew_measured retained.
REQ-030 Outputs registered; deskew_done/deskew_error assert one cycle after the deciding edge.

Reset
REQ-031 rst low: state IDLE, delay_select all 0, valid_data all 0, deskew_done 0, deskew_error 0, skew_measured 0.
REQ-032 soft_rst=1 at any state, including mid-ALIGN: identical values next edge, skew_measured also cleared.

Configuration
REQ-033 Macro LANE_DESKEW_STATS_EN defined: add output err_count (8 bits), +1 per ALIGN->ERROR transition, saturates at 255, cleared by rst/soft_rst only.
REQ-034 Macro undefined: err_count port and counter absent; all other behaviour identical.

Structure
REQ-035 Package deskew_pkg holds FSM state enum, SDS_SYMBOL default, MAX_SKEW default.
REQ-036 Sub-module deskew_lane_tracker (seen flag + delay counter per lane), instantiated LANE_COUNT times via generate.

Verification
REQ-037 x32, all lanes SDS same cycle -> LOCKED next edge, delay_select all 0, skew_measured 0.
REQ-038 x32, lane 0 SDS at t0, lane 31 at t0+6, rest t0+3 -> LOCKED; delay 6/3/0; skew_measured 6.
REQ-039 x32, lane 5 SDS at t0+7, rest t0 -> deskew_error=1 after MAX_SKEW; err_count=1 with LANE_DESKEW_STATS_EN.
REQ-040 active_lanes=0x0000000F, lanes 4..31 never send SDS -> LOCKED; valid_data[31:4]=0.
REQ-041 en dropped mid-ALIGN at t0+2 -> IDLE next edge, delays 0; re-enable and clean SDS -> LOCKED.
REQ-042 soft_rst in ERROR -> IDLE, deskew_error 0; err_count reset to 0.

Source files
------------

// File: rtl/deskew_pkg.sv
// deskew_pkg: shared FSM state encoding and default SDS/skew settings for lane deskew
package deskew_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_ALIGN, S_LOCKED, S_ERROR} deskew_state_e;
  localparam logic [7:0] SDS_SYMBOL_DEF = 8'hE1;
  localparam int MAX_SKEW_DEF = 6;
endpackage

// File: rtl/deskew_lane_tracker.sv
// deskew_lane_tracker: per-lane SDS seen flag and arrival-relative delay counter
//   RX_CLK/rst : receive clock, async active-low reset
//   clr_i      : synchronous clear (wins over everything else)
//   hit_i      : SDS observed on this lane this cycle
//   adv_i      : alignment in progress, seen lanes count up
//   seen_o     : lane has delivered its SDS
//   delay_o    : cycles elapsed since this lane's SDS (final value = delay tap)
module deskew_lane_tracker #(
  parameter int DELAY_WIDTH = 3
) (
  input  logic                   RX_CLK,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   hit_i,
  input  logic                   adv_i,
  output logic                   seen_o,
  output logic [DELAY_WIDTH-1:0] delay_o
);
  logic                   seen_q, seen_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  always_comb begin
    seen_d = clr_i ? 1'b0 : (seen_q | hit_i);
    cnt_d  = clr_i ? '0 :
             (hit_i && !seen_q) ? '0 :
             (seen_q && adv_i) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      seen_q <= seen_d;
      cnt_q  <= cnt_d;
    end
  end
  assign seen_o  = seen_q;
  assign delay_o = cnt_q;
endmodule

// File: rtl/lane_deskew_ctrl.sv
// lane_deskew_ctrl: measures per-lane SDS arrival skew and programs delay-line taps
//   RX_CLK/rst     : receive clock, async active-low reset
//   en, soft_rst   : LTSSM enable (low forces IDLE), synchronous clear
//   active_lanes   : link-width mask, latched when leaving IDLE
//   rx_data        : LANE_COUNT x DATA_WIDTH skewed symbols, block_type per lane
//   delay_select   : LANE_COUNT x DELAY_WIDTH delay taps, valid_data per lane
//   deskew_done/deskew_error/skew_measured : lock status and last locked spread
//   err_count      : ALIGN->ERROR event counter, only with LANE_DESKEW_STATS_EN
module lane_deskew_ctrl import deskew_pkg::*; #(
  parameter int LANE_COUNT  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_SKEW    = MAX_SKEW_DEF,
  parameter int DELAY_WIDTH = 3,
  parameter logic [DATA_WIDTH-1:0] SDS_SYMBOL = DATA_WIDTH'(SDS_SYMBOL_DEF)
) (
  input  logic                              RX_CLK,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              soft_rst,
  input  logic [LANE_COUNT-1:0]             active_lanes,
  input  logic [LANE_COUNT*DATA_WIDTH-1:0]  rx_data,
  input  logic [LANE_COUNT-1:0]             block_type,
  output logic [LANE_COUNT*DELAY_WIDTH-1:0] delay_select,
  output logic [LANE_COUNT-1:0]             valid_data,
  output logic                              deskew_done,
  output logic                              deskew_error,
  output logic [DELAY_WIDTH-1:0]            skew_measured
`ifdef LANE_DESKEW_STATS_EN
  ,
  output logic [7:0]                        err_count
`endif
);
  localparam logic [DELAY_WIDTH-1:0] MAX_W = DELAY_WIDTH'(MAX_SKEW);
  deskew_state_e          state_q, state_d;
  logic [LANE_COUNT-1:0]  mask_q, mask_d, valid_q, valid_d;
  logic [LANE_COUNT-1:0]  sds, hit, seen, seen_all, seen_n;
  logic [DELAY_WIDTH-1:0] skew_q, skew_d, skew_inc, meas_q, meas_d;
  logic                   done_q, done_d, err_q, err_d, tracking, all_seen, clr;
  genvar i;
  for (i = 0; i < LANE_COUNT; i++) begin : g_lane
    assign sds[i] = (rx_data[i*DATA_WIDTH +: DATA_WIDTH] == SDS_SYMBOL) && block_type[i];
    deskew_lane_tracker #(.DELAY_WIDTH(DELAY_WIDTH)) u_trk (
      .RX_CLK  (RX_CLK),
      .rst     (rst),
      .clr_i   (clr),
      .hit_i   (hit[i]),
      .adv_i   (state_q == S_ALIGN),
      .seen_o  (seen[i]),
      .delay_o (delay_select[i*DELAY_WIDTH +: DELAY_WIDTH])
    );
  end
  // all_seen includes this cycle's hits so the lock decision lands on the last arrival
  always_comb begin
    tracking = (state_q == S_SEARCH) || (state_q == S_ALIGN);
    hit      = sds & mask_q & {LANE_COUNT{tracking}};
    seen_all = seen | hit;
    all_seen = (seen_all & mask_q) == mask_q;
    skew_inc = skew_q + 1'b1;
    state_d  = (!en || soft_rst) ? S_IDLE :
               (state_q == S_IDLE)   ? ((|active_lanes) ? S_SEARCH : S_IDLE) :
               (state_q == S_SEARCH) ? (!(|hit) ? S_SEARCH : all_seen ? S_LOCKED : S_ALIGN) :
               (state_q == S_ALIGN)  ? ((all_seen && skew_inc <= MAX_W) ? S_LOCKED :
                                        (skew_inc >= MAX_W) ? S_ERROR : S_ALIGN) :
               state_q;
    clr      = state_d == S_IDLE;
    mask_d   = (state_q == S_IDLE) ? active_lanes : mask_q;
    skew_d   = (state_q == S_ALIGN) ? skew_inc : '0;
    meas_d   = soft_rst ? '0 :
               (state_d == S_LOCKED && state_q != S_LOCKED) ? ((state_q == S_ALIGN) ? skew_inc : '0) :
               meas_q;
    seen_n   = clr ? '0 : seen_all;
    valid_d  = (state_d == S_IDLE) ? '0 : mask_d & ~((state_d == S_ALIGN) ? seen_n : '0);
    done_d   = state_d == S_LOCKED;
    err_d    = state_d == S_ERROR;
  end
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      skew_q  <= '0;
      meas_q  <= '0;
      valid_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      skew_q  <= skew_d;
      meas_q  <= meas_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign valid_data    = valid_q;
  assign deskew_done   = done_q;
  assign deskew_error  = err_q;
  assign skew_measured = meas_q;
`ifdef LANE_DESKEW_STATS_EN
  logic [7:0] errc_q;
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) errc_q <= '0;
    else if (soft_rst) errc_q <= '0;
    else if (state_q == S_ALIGN && state_d == S_ERROR && errc_q != 8'hFF) errc_q <= errc_q + 1'b1;
  end
  assign err_count = errc_q;
`endif
endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// tb_lane_deskew_ctrl: directed self-checking bench for lane_deskew_ctrl (x32 defaults)
module tb_lane_deskew_ctrl;
  logic         RX_CLK = 1'b0;
  logic         rst = 1'b1, en = 1'b0, soft_rst = 1'b0;
  logic [31:0]  active_lanes = '0, block_type = '0;
  logic [255:0] rx_data = '0;
  logic [95:0]  delay_select, e;
  logic [31:0]  valid_data;
  logic         deskew_done, deskew_error;
  logic [2:0]   skew_measured;
  int           errors = 0, checks = 0;
`ifdef LANE_DESKEW_STATS_EN
  logic [7:0]   err_count;
`endif
  lane_deskew_ctrl dut (
    .RX_CLK        (RX_CLK),
    .rst           (rst),
    .en            (en),
    .soft_rst      (soft_rst),
    .active_lanes  (active_lanes),
    .rx_data       (rx_data),
    .block_type    (block_type),
    .delay_select  (delay_select),
    .valid_data    (valid_data),
    .deskew_done   (deskew_done),
    .deskew_error  (deskew_error),
    .skew_measured (skew_measured)
`ifdef LANE_DESKEW_STATS_EN
    ,
    .err_count     (err_count)
`endif
  );
  always #5 RX_CLK = ~RX_CLK;
  task automatic tick();
    @(posedge RX_CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sds(input logic [31:0] m);
    for (int i = 0; i < 32; i++) begin
      rx_data[i*8 +: 8] = m[i] ? 8'hE1 : 8'h00;
      block_type[i] = m[i];
    end
  endtask
  function automatic logic [95:0] fill(input int v);
    logic [95:0] r;
    for (int i = 0; i < 32; i++) r[i*3 +: 3] = 3'(v);
    return r;
  endfunction
  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_done", deskew_done, 0);
    chk("rst_err", deskew_error, 0);
    chk("rst_valid", valid_data, 0);
    chk("rst_delay", delay_select, 0);
    chk("rst_skew", skew_measured, 0);
    tick();
    rst = 1'b1;
    en = 1'b1;
    active_lanes = '1;
    tick();
    chk("search_valid", valid_data, 32'hFFFFFFFF);
    sds('1);
    block_type = '0;
    tick();
    chk("no_hit_without_os_valid", valid_data, 32'hFFFFFFFF);
    chk("no_hit_without_os_done", deskew_done, 0);
    sds('1);
    tick();
    chk("same_cycle_done", deskew_done, 1);
    chk("same_cycle_delay", delay_select, 0);
    chk("same_cycle_skew", skew_measured, 0);
    chk("same_cycle_valid", valid_data, 32'hFFFFFFFF);
    sds('0);
    en = 1'b0;
    tick();
    chk("idle_done", deskew_done, 0);
    chk("idle_valid", valid_data, 0);
    en = 1'b1;
    tick();
    sds(32'h00000001);
    tick();
    chk("align_first_valid", valid_data, 32'hFFFFFFFE);
    chk("align_first_done", deskew_done, 0);
    sds('0);
    tick();
    tick();
    sds(32'h7FFFFFFE);
    tick();
    chk("align_mid_valid", valid_data, 32'h80000000);
    sds('0);
    tick();
    tick();
    sds(32'h80000000);
    tick();
    e = fill(3);
    e[2:0] = 3'd6;
    e[95:93] = 3'd0;
    chk("skew6_done", deskew_done, 1);
    chk("skew6_delay", delay_select, e);
    chk("skew6_skew", skew_measured, 6);
    chk("skew6_valid", valid_data, 32'hFFFFFFFF);
    sds('0);
    en = 1'b0;
    tick();
    chk("en_low_delay", delay_select, 0);
    chk("en_low_skew_kept", skew_measured, 6);
    chk("en_low_done", deskew_done, 0);
    en = 1'b1;
    tick();
    sds(~32'h00000020);
    tick();
    sds('0);
    for (int k = 0; k < 5; k++) tick();
    chk("pre_err_err", deskew_error, 0);
    chk("pre_err_done", deskew_done, 0);
    tick();
    chk("err_set", deskew_error, 1);
    chk("err_done", deskew_done, 0);
    sds(32'h00000020);
    tick();
    e = fill(6);
    e[17:15] = 3'd0;
    chk("err_frozen_delay", delay_select, e);
    chk("err_held", deskew_error, 1);
    chk("err_valid", valid_data, 32'hFFFFFFFF);
`ifdef LANE_DESKEW_STATS_EN
    chk("err_count_one", err_count, 1);
`endif
    sds('0);
    soft_rst = 1'b1;
    tick();
    chk("soft_err", deskew_error, 0);
    chk("soft_skew", skew_measured, 0);
    chk("soft_valid", valid_data, 0);
`ifdef LANE_DESKEW_STATS_EN
    chk("soft_err_count", err_count, 0);
`endif
    soft_rst = 1'b0;
    active_lanes = 32'h0000000F;
    tick();
    chk("x4_search_valid", valid_data, 32'h0000000F);
    active_lanes = '1;
    sds(32'h0000000F);
    tick();
    chk("x4_done", deskew_done, 1);
    chk("x4_valid", valid_data, 32'h0000000F);
    sds('0);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    sds(32'h00000001);
    tick();
    sds('0);
    tick();
    chk("drop_pre_delay0", delay_select[2:0], 1);
    en = 1'b0;
    tick();
    chk("drop_delay", delay_select, 0);
    chk("drop_done", deskew_done, 0);
    chk("drop_valid", valid_data, 0);
    en = 1'b1;
    tick();
    sds('1);
    tick();
    chk("relock_done", deskew_done, 1);
    chk("relock_delay", delay_select, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
